mmio_fifo_ctrl: RTL and testbench

MMIO-mapped controller that sequences a 64-bit word FIFO on behalf of the host. It decodes host MMIO writes and reads to a small CSR window. Writes to DATA push a word; reads of DATA pop a word; PEEK, STATUS and CTRL give visibility and control. It sits inside the AFU next to the DFH/AFU-ID read logic, and the AFU read mux selects its response whenever `rsp_valid` is high.

---
 rtl/mmio_fifo_ctrl_pkg.sv | 31 +++
 rtl/mmio_fifo_ctrl_if.sv | 23 ++
 rtl/mmio_fifo_ctrl_fifo_mem.sv | 21 ++
 rtl/mmio_fifo_ctrl.sv | 114 +++++++++++
 tb/tb_mmio_fifo_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_fifo_ctrl_pkg.sv
// Shared register map, STATUS/CTRL bit positions and the STATUS word layout
// for the MMIO-mapped word FIFO controller.
package mmio_fifo_pkg;

    localparam logic [15:0] OFF_DATA   = 16'd0;
    localparam logic [15:0] OFF_PEEK   = 16'd2;
    localparam logic [15:0] OFF_STATUS = 16'd4;
    localparam logic [15:0] OFF_CTRL   = 16'd6;

    localparam int ST_COUNT_LSB = 0;
    localparam int ST_COUNT_W   = 9;
    localparam int ST_EMPTY     = 16;
    localparam int ST_FULL      = 17;
    localparam int ST_OVF       = 18;
    localparam int ST_UDF       = 19;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_CLR   = 1;

    // Field order mirrors the STATUS bit positions above, LSB last.
    typedef struct packed {
        logic [11:0] rsvd_hi;
        logic        udf;
        logic        ovf;
        logic        full;
        logic        empty;
        logic [6:0]  rsvd_lo;
        logic [8:0]  count;
    } t_fifo_status;

endpackage

// File: rtl/mmio_fifo_ctrl_if.sv
// Host MMIO request/response bundle; master is the host side, slave the FIFO controller.
interface mmio_fifo_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             mmio_wr_valid;
    logic             mmio_rd_valid;
    logic [15:0]      mmio_addr;
    logic [8:0]       mmio_tid;
    logic [WIDTH-1:0] mmio_wr_data;
    logic             rsp_valid;
    logic [8:0]       rsp_tid;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wr_data,
        input  rsp_valid, rsp_tid, rsp_data
    );

    modport slave (
        input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wr_data,
        output rsp_valid, rsp_tid, rsp_data
    );
endinterface

// File: rtl/mmio_fifo_ctrl_fifo_mem.sv
// FIFO storage: one synchronous write port, asynchronous read at the read pointer.
module fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_wr_ptr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_ptr,
    output logic [WIDTH-1:0]         o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents need no reset: a flush or reset empties the FIFO via count.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_ptr];
endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO CSR decode, pointer/count/flag sequencing and 1-cycle read response
// for a circular word FIFO.
module mmio_fifo_ctrl
    import mmio_fifo_pkg::*;
#(
    parameter int          DEPTH = 8,
    parameter int          WIDTH = 64,
    parameter logic [15:0] BASE  = 16'h0020
) (
    input  logic              clk,
    input  logic              rst,
    mmio_fifo_ctrl_if.slave   bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    r_rd_ptr, r_wr_ptr;
    logic [AW:0]      r_count;
    logic             r_ovf, r_udf;
    logic             r_rsp_valid;
    logic [8:0]       r_rsp_tid;
    logic [WIDTH-1:0] r_rsp_data;

    logic             w_hit_data, w_hit_peek, w_hit_stat, w_hit_ctrl, w_rd_hit;
    logic             w_empty, w_full, w_push, w_pop, w_flush, w_clr;
    logic             w_ovf_set, w_udf_set;
    logic [WIDTH-1:0] w_head, w_rsp_data;
    t_fifo_status     w_status;

    assign w_hit_data = (bus.mmio_addr == BASE + OFF_DATA);
    assign w_hit_peek = (bus.mmio_addr == BASE + OFF_PEEK);
    assign w_hit_stat = (bus.mmio_addr == BASE + OFF_STATUS);
    assign w_hit_ctrl = (bus.mmio_addr == BASE + OFF_CTRL);
    assign w_rd_hit   = bus.mmio_rd_valid & (w_hit_data | w_hit_peek | w_hit_stat | w_hit_ctrl);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // Push and pop both see start-of-cycle state; a pop frees the slot a
    // simultaneous push on a full FIFO needs.
    assign w_pop     = bus.mmio_rd_valid & w_hit_data & ~w_empty;
    assign w_push    = bus.mmio_wr_valid & w_hit_data & (~w_full | w_pop);
    assign w_ovf_set = bus.mmio_wr_valid & w_hit_data & ~w_push;
    assign w_udf_set = bus.mmio_rd_valid & w_hit_data & w_empty;
    assign w_flush   = bus.mmio_wr_valid & w_hit_ctrl & bus.mmio_wr_data[CTRL_FLUSH];
    assign w_clr     = bus.mmio_wr_valid & w_hit_ctrl & bus.mmio_wr_data[CTRL_CLR];

    always_comb begin
        w_status       = '0;
        w_status.count = 9'(r_count);
        w_status.empty = w_empty;
        w_status.full  = w_full;
        w_status.ovf   = r_ovf;
        w_status.udf   = r_udf;
    end

    always_comb begin
        w_rsp_data = '0;
        if (w_hit_data | w_hit_peek) w_rsp_data = w_empty ? '0 : w_head;
        else if (w_hit_stat)         w_rsp_data = WIDTH'(w_status);
    end

    fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
        .clk       (clk),
        .i_we      (w_push & ~w_flush),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data (bus.mmio_wr_data),
        .i_rd_ptr  (r_rd_ptr),
        .o_rd_data (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_tid   <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_rd_hit;
            if (w_rd_hit) begin
                r_rsp_tid  <= bus.mmio_tid;
                r_rsp_data <= w_rsp_data;
            end

            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: ;
                endcase
            end

            // A set in the same cycle as a clear takes priority.
            if (w_ovf_set)  r_ovf <= 1'b1;
            else if (w_clr) r_ovf <= 1'b0;
            if (w_udf_set)  r_udf <= 1'b1;
            else if (w_clr) r_udf <= 1'b0;
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_tid   = r_rsp_tid;
    assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Randomised and directed bench for mmio_fifo_ctrl against a queue-based host-view model.
module tb_mmio_fifo_ctrl;
    localparam int          DEPTH  = 8;
    localparam int          WIDTH  = 64;
    localparam logic [15:0] BASE   = 16'h0020;
    localparam logic [15:0] A_DATA = BASE;
    localparam logic [15:0] A_PEEK = BASE + 16'd2;
    localparam logic [15:0] A_STAT = BASE + 16'd4;
    localparam logic [15:0] A_CTRL = BASE + 16'd6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmio_fifo_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mmio_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BASE(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errs   = 0;
    int checks = 0;

    logic [63:0] q[$];
    bit          m_ovf, m_udf;

    logic        ev, gv;
    logic [63:0] ed, gd;
    logic [8:0]  et, gt;

    // One host cycle: compute expected response from the model, drive, sample after the edge.
    task automatic step(input logic wr, input logic rd, input logic [15:0] a, input logic [63:0] wd);
        int n;
        logic emp, ful, pop, push, mapped;
        logic [63:0] head;
        n      = q.size();
        emp    = (n == 0);
        ful    = (n == DEPTH);
        head   = emp ? 64'd0 : q[0];
        mapped = (a == A_DATA) || (a == A_PEEK) || (a == A_STAT) || (a == A_CTRL);
        et     = 9'($urandom);
        ev     = rd && mapped;
        ed     = '0;
        if (rd && (a == A_DATA || a == A_PEEK)) ed = head;
        else if (rd && a == A_STAT) begin
            ed[8:0] = n[8:0];
            ed[16]  = emp;
            ed[17]  = ful;
            ed[18]  = m_ovf;
            ed[19]  = m_udf;
        end
        pop  = rd && a == A_DATA && !emp;
        push = wr && a == A_DATA && (!ful || pop);
        if (wr && a == A_CTRL && wd[1]) begin m_ovf = 0; m_udf = 0; end
        if (wr && a == A_DATA && !push) m_ovf = 1;
        if (rd && a == A_DATA && emp)   m_udf = 1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(wd);
        if (wr && a == A_CTRL && wd[0]) q.delete();

        bus.mmio_wr_valid = wr;
        bus.mmio_rd_valid = rd;
        bus.mmio_addr     = a;
        bus.mmio_tid      = et;
        bus.mmio_wr_data  = wd;
        @(posedge clk); #1;
        gv = bus.rsp_valid;
        gt = bus.rsp_tid;
        gd = bus.rsp_data;
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mmio_wr_valid = 0; bus.mmio_rd_valid = 0;
        bus.mmio_addr = '0; bus.mmio_tid = '0; bus.mmio_wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_tid !== 9'd0 || bus.rsp_data !== 64'd0) begin
            errs++;
            $display("FAIL reset_outputs: got v=%0b tid=%0h d=%h, want all zero", bus.rsp_valid, bus.rsp_tid, bus.rsp_data);
        end
        rst = 1'b0;
        q.delete(); m_ovf = 0; m_udf = 0;
        step(0, 1, A_STAT, 0);
        checks++;
        if (gv !== 1'b1 || gt !== et || gd !== 64'h1_0000) begin
            errs++;
            $display("FAIL reset_status: got v=%0b tid=%0h d=%h, want v=1 tid=%0h d=%h", gv, gt, gd, et, 64'h1_0000);
        end
    endtask

    task automatic test_basic();
        logic [63:0] exp_rd [4];
        exp_rd = '{64'hA1, 64'hB2, 64'hC3, 64'h0};
        step(1, 0, A_CTRL, 64'h3);
        step(1, 0, A_DATA, 64'hA1);
        checks++;
        if (gv !== 1'b0) begin errs++; $display("FAIL basic_write_rsp: got v=%0b, want v=0", gv); end
        step(1, 0, A_DATA, 64'hB2);
        step(1, 0, A_DATA, 64'hC3);
        step(0, 1, A_PEEK, 0);
        checks++;
        if (gv !== 1'b1 || gt !== et || gd !== 64'hA1) begin
            errs++; $display("FAIL basic_peek: got v=%0b tid=%0h d=%h, want v=1 tid=%0h d=a1", gv, gt, gd, et);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, A_DATA, 0);
            checks++;
            if (gv !== 1'b1 || gt !== et || gd !== exp_rd[i]) begin
                errs++; $display("FAIL basic_pop%0d: got v=%0b tid=%0h d=%h, want v=1 tid=%0h d=%h", i, gv, gt, gd, et, exp_rd[i]);
            end
        end
        step(0, 1, A_STAT, 0);
        checks++;
        if (gv !== 1'b1 || gd !== 64'h9_0000 || gd !== ed) begin
            errs++; $display("FAIL basic_underflow_status: got d=%h, want d=%h", gd, 64'h9_0000);
        end
    endtask

    task automatic test_overflow();
        step(1, 0, A_CTRL, 64'h3);
        for (int i = 1; i <= 9; i++) step(1, 0, A_DATA, 64'(i));
        step(0, 1, A_STAT, 0);
        checks++;
        if (gv !== 1'b1 || gd !== 64'h6_0008) begin
            errs++; $display("FAIL ovf_status: got v=%0b d=%h, want v=1 d=%h", gv, gd, 64'h6_0008);
        end
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, A_DATA, 0);
            checks++;
            if (gv !== 1'b1 || gt !== et || gd !== 64'(i)) begin
                errs++; $display("FAIL ovf_pop%0d: got v=%0b tid=%0h d=%h, want v=1 tid=%0h d=%0d", i, gv, gt, gd, et, i);
            end
        end
        step(0, 1, A_STAT, 0);
        checks++;
        if (gd !== ed || gd !== 64'h5_0000) begin
            errs++; $display("FAIL ovf_drained_status: got d=%h, want d=%h", gd, 64'h5_0000);
        end
    endtask

    task automatic test_wrap();
        step(1, 0, A_CTRL, 64'h3);
        for (int k = 0; k < 20; k++) begin
            step(1, 0, A_DATA, 64'(1000 + k));
            step(0, 1, A_STAT, 0);
            checks++;
            if (gd[8:0] > 9'd1 || gd !== ed) begin
                errs++; $display("FAIL wrap_status%0d: got d=%h, want d=%h", k, gd, ed);
            end
            step(0, 1, A_DATA, 0);
            checks++;
            if (gv !== 1'b1 || gd !== 64'(1000 + k)) begin
                errs++; $display("FAIL wrap_pop%0d: got v=%0b d=%h, want v=1 d=%0d", k, gv, gd, 1000 + k);
            end
        end
    endtask

    task automatic test_ctrl();
        step(1, 0, A_CTRL, 64'h3);
        step(0, 1, A_DATA, 0);
        for (int i = 0; i < 9; i++) step(1, 0, A_DATA, 64'($urandom));
        for (int i = 0; i < 3; i++) step(0, 1, A_DATA, 0);
        step(0, 1, A_STAT, 0);
        checks++;
        if (gd !== 64'hC_0005 || gd !== ed) begin
            errs++; $display("FAIL ctrl_pre_status: got d=%h, want d=%h", gd, 64'hC_0005);
        end
        step(1, 0, A_CTRL, 64'h3);
        step(0, 1, A_STAT, 0);
        checks++;
        if (gv !== 1'b1 || gd !== 64'h1_0000) begin
            errs++; $display("FAIL ctrl_flush_status: got v=%0b d=%h, want v=1 d=%h", gv, gd, 64'h1_0000);
        end
        step(1, 0, A_DATA, 64'hDEAD_BEEF_0123_4567);
        step(0, 1, A_DATA, 0);
        checks++;
        if (gv !== 1'b1 || gd !== 64'hDEAD_BEEF_0123_4567) begin
            errs++; $display("FAIL ctrl_wr_then_rd: got v=%0b d=%h, want v=1 d=deadbeef01234567", gv, gd);
        end
        step(0, 1, A_CTRL, 0);
        checks++;
        if (gv !== 1'b1 || gt !== et || gd !== 64'd0) begin
            errs++; $display("FAIL ctrl_read: got v=%0b tid=%0h d=%h, want v=1 tid=%0h d=0", gv, gt, gd, et);
        end
    endtask

    task automatic test_simul();
        step(1, 0, A_CTRL, 64'h3);
        for (int i = 1; i <= DEPTH; i++) step(1, 0, A_DATA, 64'(i));
        step(1, 1, A_DATA, 64'h77);
        checks++;
        if (gv !== 1'b1 || gd !== 64'd1) begin
            errs++; $display("FAIL simul_full_pop: got v=%0b d=%h, want v=1 d=1", gv, gd);
        end
        step(0, 1, A_STAT, 0);
        checks++;
        if (gd !== 64'h2_0008 || gd !== ed) begin
            errs++; $display("FAIL simul_full_status: got d=%h, want d=%h", gd, 64'h2_0008);
        end
        step(1, 0, A_CTRL, 64'h3);
        step(1, 1, A_DATA, 64'h55);
        checks++;
        if (gv !== 1'b1 || gd !== 64'd0) begin
            errs++; $display("FAIL simul_empty_pop: got v=%0b d=%h, want v=1 d=0", gv, gd);
        end
        step(0, 1, A_STAT, 0);
        checks++;
        if (gd !== 64'h8_0001 || gd !== ed) begin
            errs++; $display("FAIL simul_empty_status: got d=%h, want d=%h", gd, 64'h8_0001);
        end
        step(1, 1, A_CTRL, 64'h1);
        step(0, 1, A_STAT, 0);
        checks++;
        if (gd !== 64'h9_0000 || gd !== ed) begin
            errs++; $display("FAIL simul_ctrl_flush: got d=%h, want d=%h", gd, 64'h9_0000);
        end
    endtask

    task automatic test_unmapped();
        logic [15:0] addrs [3];
        addrs = '{16'h0000, 16'h0028, BASE + 16'd1};
        step(1, 0, A_DATA, 64'h42);
        foreach (addrs[i]) begin
            step(1, 1, addrs[i], 64'h3);
            checks++;
            if (gv !== 1'b0) begin
                errs++; $display("FAIL unmapped_rd_%h: got v=%0b, want v=0", addrs[i], gv);
            end
        end
        step(0, 1, A_STAT, 0);
        checks++;
        if (gv !== 1'b1 || gd !== ed) begin
            errs++; $display("FAIL unmapped_status: got v=%0b d=%h, want v=1 d=%h", gv, gd, ed);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, A_DATA, 64'h11);
        step(1, 0, A_DATA, 64'h22);
        rst = 1'b1;
        bus.mmio_rd_valid = 1'b1;
        bus.mmio_addr     = A_DATA;
        bus.mmio_tid      = 9'h1AB;
        @(posedge clk); #1;
        bus.mmio_rd_valid = 1'b0;
        rst = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 64'd0) begin
            errs++; $display("FAIL reset_mid_rsp: got v=%0b d=%h, want v=0 d=0", bus.rsp_valid, bus.rsp_data);
        end
        q.delete(); m_ovf = 0; m_udf = 0;
        step(0, 1, A_STAT, 0);
        checks++;
        if (gv !== 1'b1 || gd !== 64'h1_0000) begin
            errs++; $display("FAIL reset_mid_status: got v=%0b d=%h, want v=1 d=%h", gv, gd, 64'h1_0000);
        end
    endtask

    task automatic test_random();
        logic [15:0] addrs [6];
        logic [15:0] a;
        logic [63:0] wd;
        logic wr, rd;
        addrs = '{A_DATA, A_PEEK, A_STAT, A_CTRL, 16'h0028, 16'h0000};
        for (int i = 0; i < 400; i++) begin
            a  = (i % 3 == 0) ? A_DATA : addrs[$urandom_range(5)];
            wr = ($urandom_range(1) == 1);
            rd = ($urandom_range(1) == 1);
            wd = {32'($urandom), 32'($urandom)};
            if (a == A_CTRL) begin
                wd[0] = ($urandom_range(7) == 0);
                wd[1] = ($urandom_range(3) == 0);
            end
            step(wr, rd, a, wd);
            checks++;
            if (gv !== ev || (ev && (gt !== et || gd !== ed))) begin
                errs++;
                $display("FAIL random%0d: wr=%0b rd=%0b a=%h got v=%0b tid=%0h d=%h, want v=%0b tid=%0h d=%h",
                         i, wr, rd, a, gv, gt, gd, ev, et, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_wrap();
        test_ctrl();
        test_simul();
        test_unmapped();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
